// File: rtl/crossing_gate_controller.sv
// Per-crossing warning/gate sequencer: lights, gate motor commands and limit-switch
// supervision with movement timeouts and a sticky fail-safe fault state.
module crossing_gate_controller #(
  parameter int unsigned WARN_CYCLES  = 1000,
  parameter int unsigned MOVE_TIMEOUT = 5000,
  parameter int unsigned CLEAR_CYCLES = 500,
  parameter int unsigned BLINK_CYCLES = 250,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       train_detected,
  input  logic       train_exited,
  input  logic [1:0] weather_mode,
  input  logic       gate_down_limit,
  input  logic       gate_up_limit,
  input  logic       fault_clr,
  output logic       warning_active,
  output logic       lights_flash,
  output logic       gate_lower,
  output logic       gate_raise,
  output logic       crossing_closed,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WARN     = 3'd1,
    S_LOWERING = 3'd2,
    S_CLOSED   = 3'd3,
    S_CLEARING = 3'd4,
    S_RAISING  = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] L_WARN  = CNT_W'(WARN_CYCLES);
  localparam logic [CNT_W-1:0] L_MOVE  = CNT_W'(MOVE_TIMEOUT);
  localparam logic [CNT_W-1:0] L_CLEAR = CNT_W'(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] L_BLINK = CNT_W'(BLINK_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_next;
  logic [CNT_W-1:0] w_warn_load;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic             w_expired;
  logic             w_both_limits;

  // A load of N keeps the FSM in the timed state for exactly N cycles, so expiry
  // is taken on the cycle the timer would decrement to zero.
  assign w_expired     = (r_timer <= CNT_W'(1));
  assign w_both_limits = gate_down_limit & gate_up_limit;
  assign w_warn_load   = L_WARN * (CNT_W'(weather_mode) + CNT_W'(1));

  always_comb begin
    w_next       = r_state;
    w_timer_next = (r_timer == '0) ? '0 : r_timer - CNT_W'(1);
    if (r_state != S_IDLE && w_both_limits) begin
      w_next = S_FAULT;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (train_detected) begin
            w_next       = S_WARN;
            w_timer_next = w_warn_load;
          end
        end
        S_WARN: begin
          if (w_expired) begin
            w_next       = S_LOWERING;
            w_timer_next = L_MOVE;
          end
        end
        S_LOWERING: begin
          if (gate_down_limit) begin
            w_next = S_CLOSED;
          end else if (w_expired) begin
            w_next = S_FAULT;
          end
        end
        S_CLOSED: begin
          if (!gate_down_limit) begin
            w_next = S_FAULT;
          end else if (train_exited && !train_detected) begin
            w_next       = S_CLEARING;
            w_timer_next = L_CLEAR;
          end
        end
        S_CLEARING: begin
          if (train_detected) begin
            w_next = S_CLOSED;
          end else if (w_expired) begin
            w_next       = S_RAISING;
            w_timer_next = L_MOVE;
          end
        end
        S_RAISING: begin
          if (gate_up_limit) begin
            w_next = S_IDLE;
          end else if (train_detected) begin
            w_next       = S_LOWERING;
            w_timer_next = L_MOVE;
          end else if (w_expired) begin
            w_next = S_FAULT;
          end
        end
        S_FAULT: begin
          if (fault_clr && !train_detected) begin
            w_next       = S_RAISING;
            w_timer_next = L_MOVE;
          end
        end
        default: w_next = S_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer_next;
    end
  end

  // Held at phase 0 while idle, so every warning sequence starts dark.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt >= L_BLINK) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    warning_active  = (r_state != S_IDLE);
    lights_flash    = (r_state != S_IDLE) & r_blink_phase;
    gate_lower      = (r_state == S_LOWERING) || (r_state == S_CLOSED) ||
                      (r_state == S_CLEARING) || (r_state == S_FAULT);
    gate_raise      = (r_state == S_RAISING);
    crossing_closed = (r_state == S_CLOSED) || (r_state == S_CLEARING);
    fault           = (r_state == S_FAULT);
    state           = r_state;
  end

endmodule

// File: tb/tb_crossing_gate_controller.sv
// Self-checking bench for crossing_gate_controller: vector table plus blink sequence,
// expectations queued on drive and compared one cycle later.
module tb_crossing_gate_controller;

  localparam logic [2:0] IDLE = 3'd0, WARN = 3'd1, LOW = 3'd2, CLOSED = 3'd3,
                         CLEARING = 3'd4, RAISING = 3'd5, FAULT = 3'd6;
  localparam logic [8:0] M_ALL     = 9'h1FF;
  localparam logic [8:0] M_NOFLASH = 9'b1_0111_1111;

  logic       clk = 1'b0;
  logic       rst, train_detected, train_exited;
  logic [1:0] weather_mode;
  logic       gate_down_limit, gate_up_limit, fault_clr;
  logic       warning_active, lights_flash, gate_lower, gate_raise;
  logic       crossing_closed, fault;
  logic [2:0] state;
  logic [8:0] w_out;

  int n_pass  = 0;
  int n_total = 0;
  bit armed   = 1'b0;

  typedef struct {
    logic       rst, det, ext;
    logic [1:0] wx;
    logic       dl, ul, clr;
    int         n;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    logic [8:0] val;
    logic [8:0] mask;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  crossing_gate_controller #(
    .WARN_CYCLES (10),
    .MOVE_TIMEOUT(20),
    .CLEAR_CYCLES(5),
    .BLINK_CYCLES(2),
    .CNT_W       (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .train_detected (train_detected),
    .train_exited   (train_exited),
    .weather_mode   (weather_mode),
    .gate_down_limit(gate_down_limit),
    .gate_up_limit  (gate_up_limit),
    .fault_clr      (fault_clr),
    .warning_active (warning_active),
    .lights_flash   (lights_flash),
    .gate_lower     (gate_lower),
    .gate_raise     (gate_raise),
    .crossing_closed(crossing_closed),
    .fault          (fault),
    .state          (state)
  );

  always #5 clk = ~clk;

  assign w_out = {warning_active, lights_flash, gate_lower, gate_raise,
                  crossing_closed, fault, state};

  // Expected outputs per state: {warn, flash, lower, raise, closed, fault, state}
  function automatic logic [8:0] exp_vec(input logic [2:0] st);
    case (st)
      IDLE:     return {6'b000000, st};
      WARN:     return {6'b100000, st};
      LOW:      return {6'b101000, st};
      CLOSED:   return {6'b101010, st};
      CLEARING: return {6'b101010, st};
      RAISING:  return {6'b100100, st};
      FAULT:    return {6'b101001, st};
      default:  return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] mask_for(input logic [2:0] st);
    return (st == IDLE) ? M_ALL : M_NOFLASH;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      n_total++;
      if (gate_lower && gate_raise)
        $display("FAIL motor_excl: lower=%b raise=%b required not both 1 at %0t",
                 gate_lower, gate_raise, $time);
      else
        n_pass++;
    end
  end

  task automatic drive(input vec_t v);
    rst             = v.rst;
    train_detected  = v.det;
    train_exited    = v.ext;
    weather_mode    = v.wx;
    gate_down_limit = v.dl;
    gate_up_limit   = v.ul;
    fault_clr       = v.clr;
  endtask

  task automatic tick(input string tag, input logic [8:0] val, input logic [8:0] mask);
    exp_t e;
    sb.push_back('{val: val, mask: mask, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_total++;
    if ((w_out & e.mask) !== (e.val & e.mask))
      $display("FAIL %s: got %b required %b (mask %b)", e.tag, w_out, e.val, e.mask);
    else
      n_pass++;
  endtask

  task automatic add(input logic r, input logic d, input logic x, input logic [1:0] w,
                     input logic dl, input logic ul, input logic c, input int n,
                     input logic [2:0] st);
    vec_t v;
    v.rst = r; v.det = d; v.ext = x; v.wx = w;
    v.dl = dl; v.ul = ul; v.clr = c; v.n = n; v.st = st;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    v = '{rst: 1'b1, det: 1'b0, ext: 1'b0, wx: 2'd0, dl: 1'b0, ul: 1'b0, clr: 1'b0,
          n: 1, st: IDLE};
    drive(v);

    // nominal pass, exit while still detected, clear and raise
    add(1,0,0,0,0,0,0, 1,IDLE);
    add(0,1,0,0,0,0,0, 1,WARN);
    add(0,0,0,0,0,0,0, 9,WARN);
    add(0,0,0,0,0,0,0, 1,LOW);
    add(0,0,0,0,0,0,0, 2,LOW);
    add(0,0,0,0,1,0,0, 1,CLOSED);
    add(0,1,1,0,1,0,0, 2,CLOSED);
    add(0,0,0,0,1,0,0, 1,CLOSED);
    add(0,0,1,0,1,0,0, 1,CLEARING);
    add(0,0,0,0,1,0,0, 4,CLEARING);
    add(0,0,0,0,0,0,0, 1,RAISING);
    add(0,0,0,0,0,1,0, 1,IDLE);
    add(0,0,0,0,0,1,0, 2,IDLE);
    // storm warning (40), second train in CLEARING, down-limit loss in CLOSED
    add(0,1,0,3,0,0,0, 1,WARN);
    add(0,0,0,0,0,0,0,39,WARN);
    add(0,0,0,0,0,0,0, 1,LOW);
    add(0,0,0,0,1,0,0, 1,CLOSED);
    add(0,0,1,0,1,0,0, 1,CLEARING);
    add(0,0,0,0,1,0,0, 2,CLEARING);
    add(0,1,0,0,1,0,0, 1,CLOSED);
    add(0,0,0,0,0,0,0, 1,FAULT);
    add(0,0,0,0,0,0,1, 1,RAISING);
    add(0,0,0,0,0,1,0, 1,IDLE);
    // fog warning (30), weather change mid-WARN ignored
    add(0,1,0,2,0,0,0, 1,WARN);
    add(0,0,0,0,0,0,0,29,WARN);
    add(0,1,0,0,0,0,0, 1,LOW);
    // lowering timeout, fault_clr gated by detection, raising timeout
    add(0,1,0,0,0,0,0,19,LOW);
    add(0,1,0,0,0,0,0, 1,FAULT);
    add(0,1,0,0,0,0,1, 3,FAULT);
    add(0,0,0,0,0,0,1, 1,RAISING);
    add(0,0,0,0,0,0,0,19,RAISING);
    add(0,0,0,0,0,0,0, 1,FAULT);
    // re-detect during RAISING
    add(0,0,0,0,0,0,1, 1,RAISING);
    add(0,1,0,0,0,0,0, 1,LOW);
    add(0,1,0,0,1,0,0, 1,CLOSED);
    // both limits, clear blocked, reset mid-LOWERING
    add(0,1,0,0,1,1,0, 1,FAULT);
    add(0,1,0,0,1,1,1, 2,FAULT);
    add(0,0,0,0,1,1,1, 1,FAULT);
    add(0,0,0,0,0,0,1, 1,RAISING);
    add(0,1,0,0,0,0,0, 1,LOW);
    add(0,1,0,0,0,0,0, 3,LOW);
    add(1,1,0,0,0,0,0, 1,IDLE);
    add(0,0,0,0,0,0,0, 2,IDLE);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      for (int j = 0; j < tbl[i].n; j++) begin
        tick($sformatf("vec%0d_cyc%0d", i, j), exp_vec(tbl[i].st), mask_for(tbl[i].st));
        armed = 1'b1;
      end
    end

    // Blink: phase starts 0 at WARN entry and toggles every 2 cycles
    v = '{rst: 1'b1, det: 1'b0, ext: 1'b0, wx: 2'd0, dl: 1'b0, ul: 1'b0, clr: 1'b0,
          n: 1, st: IDLE};
    drive(v);
    tick("blink_rst", exp_vec(IDLE), M_ALL);
    v.rst = 1'b0;
    v.det = 1'b1;
    drive(v);
    for (int k = 0; k <= 10; k++) begin
      logic [8:0] e;
      e    = exp_vec((k < 10) ? WARN : LOW);
      e[7] = ((k / 2) % 2) == 1;
      tick($sformatf("blink_k%0d", k), e, M_ALL);
      v.det = 1'b0;
      drive(v);
    end
    v.rst = 1'b1;
    drive(v);
    tick("blink_idle_after_rst", exp_vec(IDLE), M_ALL);
    v.rst = 1'b0;
    drive(v);
    tick("blink_idle_hold", exp_vec(IDLE), M_ALL);

    armed = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
